// File: rtl/level_controller.sv
// Level sequencing FSM for a game: IDLE -> PLAY -> ADVANCE/OVER/WIN, with registered outputs.
// Optional macro LEVEL_BLINK_EN makes the level display blink during ADVANCE.
module level_controller #(
  parameter logic [4:0] MAX_LEVEL      = 5'd30,
  parameter int         BLINK_CYCLES   = 25_000_000,
  parameter int         ADVANCE_BLINKS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       level_done,
  input  logic       fail,
  output logic [4:0] current_level,
  output logic       on,
  output logic       level_start,
  output logic       game_over,
  output logic       game_won
);

  localparam int ADV_TOTAL = 2 * BLINK_CYCLES * ADVANCE_BLINKS;
  localparam int CNT_W     = (ADV_TOTAL > 1) ? $clog2(ADV_TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ADV_TOTAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    ADVANCE,
    OVER,
    WIN
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_d;
  logic [4:0]       level_d;
  logic             on_d;
  logic             level_start_d;
  logic             game_over_d;
  logic             game_won_d;

`ifdef LEVEL_BLINK_EN
  localparam int HALF_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(BLINK_CYCLES - 1);
  logic [HALF_W-1:0] half_cnt, half_cnt_d;
`endif

  // State register; all outputs are registered alongside it so they change with the state.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state         <= IDLE;
      blink_cnt     <= '0;
      current_level <= 5'd1;
      on            <= 1'b0;
      level_start   <= 1'b0;
      game_over     <= 1'b0;
      game_won      <= 1'b0;
`ifdef LEVEL_BLINK_EN
      half_cnt      <= '0;
`endif
    end else begin
      state         <= state_d;
      blink_cnt     <= blink_cnt_d;
      current_level <= level_d;
      on            <= on_d;
      level_start   <= level_start_d;
      game_over     <= game_over_d;
      game_won      <= game_won_d;
`ifdef LEVEL_BLINK_EN
      half_cnt      <= half_cnt_d;
`endif
    end
  end

  // Next-state and level/blink-counter update.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state;
    blink_cnt_d = blink_cnt;
    level_d     = current_level;
    case (state)
      IDLE: begin
        level_d = 5'd1;
        if (start) state_d = PLAY;
      end
      PLAY: begin
        if (fail) begin
          state_d = OVER;
        end else if (level_done) begin
          if (current_level >= MAX_LEVEL) begin
            state_d = WIN;
          end else begin
            state_d     = ADVANCE;
            blink_cnt_d = '0;
          end
        end
      end
      ADVANCE: begin
        if (blink_cnt == LAST_CNT) begin
          state_d     = PLAY;
          blink_cnt_d = '0;
          if (current_level < MAX_LEVEL) level_d = current_level + 5'd1;
        end else begin
          blink_cnt_d = blink_cnt + CNT_W'(1);
        end
      end
      OVER, WIN: begin
        if (start) begin
          state_d = PLAY;
          level_d = 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 5'd1;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the transition being taken.
  always_comb begin
    on_d          = (state_d != IDLE);
    level_start_d = (state_d == PLAY) && (state != PLAY);
    game_over_d   = (state_d == OVER);
    game_won_d    = (state_d == WIN);
`ifdef LEVEL_BLINK_EN
    half_cnt_d    = '0;
    if (state_d == ADVANCE) begin
      if (state != ADVANCE) begin
        on_d = 1'b0;
      end else if (half_cnt == LAST_HALF) begin
        on_d = ~on;
      end else begin
        on_d       = on;
        half_cnt_d = half_cnt + HALF_W'(1);
      end
    end
`endif
  end

endmodule

// File: tb/tb_level_controller.sv
// Self-checking bench for level_controller: directed scenarios plus random stimulus
// compared every cycle against a cycle-count based reference model.
module tb_level_controller;

  localparam int         BC    = 4;
  localparam int         AB    = 2;
  localparam int         TOTAL = 2 * BC * AB;
  localparam logic [4:0] ML    = 5'd3;

  logic       CLK = 1'b0;
  logic       RST, start, level_done, fail;
  logic [4:0] current_level;
  logic       on, level_start, game_over, game_won;

  always #5 CLK = ~CLK;

  level_controller #(
    .MAX_LEVEL(ML), .BLINK_CYCLES(BC), .ADVANCE_BLINKS(AB)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .level_done(level_done), .fail(fail),
    .current_level(current_level), .on(on), .level_start(level_start),
    .game_over(game_over), .game_won(game_won)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 play, 2 advance, 3 over, 4 win.
  int m_mode    = 0;
  int m_level   = 1;
  int m_elapsed = 0;
  bit m_pulse   = 0;

  task automatic model_edge(input bit r, input bit s, input bit d, input bit f);
    m_pulse = 0;
    if (r) begin
      m_mode = 0; m_level = 1; m_elapsed = 0;
    end else begin
      case (m_mode)
        0: if (s) begin m_mode = 1; m_level = 1; m_pulse = 1; end
        1: begin
          if (f) m_mode = 3;
          else if (d) begin
            if (m_level == int'(ML)) m_mode = 4;
            else begin m_mode = 2; m_elapsed = 0; end
          end
        end
        2: begin
          if (m_elapsed == TOTAL - 1) begin
            m_mode = 1; m_level = m_level + 1; m_pulse = 1;
          end else m_elapsed++;
        end
        default: if (s) begin m_mode = 1; m_level = 1; m_pulse = 1; end
      endcase
    end
  endtask

  function automatic bit exp_on();
    if (m_mode == 0) return 1'b0;
`ifdef LEVEL_BLINK_EN
    if (m_mode == 2) return ((m_elapsed / BC) % 2) == 1;
`endif
    return 1'b1;
  endfunction

  task automatic cycle(input bit r, input bit s, input bit d, input bit f);
    RST = r; start = s; level_done = d; fail = f;
    @(posedge CLK);
    model_edge(r, s, d, f);
    #1;
    check("current_level", current_level, m_level);
    check("on",            on,            exp_on());
    check("level_start",   level_start,   m_pulse);
    check("game_over",     game_over,     m_mode == 3);
    check("game_won",      game_won,      m_mode == 4);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; level_done = 1'b0; fail = 1'b0;
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("reset_level", current_level, 1);
    check("reset_on",    on,            0);

    // Start pulse enters PLAY at level 1 with a single level_start.
    cycle(0, 1, 0, 0);
    check("start_ls",  level_start, 1);
    check("start_on",  on,          1);
    cycle(0, 1, 0, 0);
    check("start_held_ls", level_start, 0);
    cycle(0, 1, 0, 0);
    idle_cycles(2);

    // Level 1 cleared: 16 ADVANCE cycles, with inputs ignored along the way.
    cycle(0, 0, 1, 0);
    idle_cycles(3);
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    check("adv_hold_level", current_level, 1);
    idle_cycles(9);
    check("adv_still_level", current_level, 1);
    idle_cycles(1);
    check("adv_next_level", current_level, 2);
    check("adv_next_ls",    level_start,   1);

    // Simultaneous done and fail: fail wins.
    cycle(0, 0, 1, 1);
    check("over_flag",  game_over,     1);
    check("over_level", current_level, 2);
    cycle(0, 0, 1, 1);
    cycle(0, 1, 0, 0);
    check("restart_level", current_level, 1);
    check("restart_ls",    level_start,   1);

    // Clear all three levels -> WIN at level 3.
    cycle(0, 0, 1, 0); idle_cycles(TOTAL);
    cycle(0, 0, 1, 0); idle_cycles(TOTAL);
    check("lvl3", current_level, 3);
    cycle(0, 0, 1, 0);
    check("win_flag",  game_won,      1);
    check("win_level", current_level, 3);
    cycle(0, 0, 1, 1);
    idle_cycles(TOTAL + 2);
    check("win_stays_level", current_level, 3);

    // Reset on cycle 7 of ADVANCE at level 2.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0); idle_cycles(TOTAL);
    cycle(0, 0, 1, 0);
    idle_cycles(6);
    cycle(1, 0, 0, 0);
    check("rst_adv_level", current_level, 1);
    check("rst_adv_on",    on,            0);
    check("rst_adv_ls",    level_start,   0);

    // done/fail in IDLE are ignored.
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    check("idle_ignore_on", on, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 5) == 0,   $urandom_range(0, 29) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
